// File: rtl/data_receiver.sv
// data_receiver: rebuilds 40-bit words from a byte stream, LSB byte first.
// Latency: dataOut and data_valid update one cycle after the clock edge that samples the last byte.
// Backpressure: none. Every byte_valid cycle is accepted, and nothing upstream is ever stalled.
//
// Optional feature: define DATA_RECEIVER_CHECKSUM_EN to turn on checksum mode.
// In that mode each word is followed by a sixth byte holding the XOR of bytes 1..5.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   rst            asynchronous, active-low reset
//   byte_in        received byte from the UART receiver
//   byte_valid     single-cycle strobe qualifying byte_in (held high = one byte per cycle)
//   dataOut        last complete word (registered); partial words are never visible here
//   data_valid     one-cycle pulse when dataOut updates
//   timeout        one-cycle pulse when a partial word is dropped after too long an idle gap
//   checksum_error one-cycle pulse on a checksum mismatch; constant 0 without checksum mode
//   byte_count     bytes held for the word in progress (0..5)
module data_receiver #(
  // Maximum idle cycles allowed between bytes of one word (2..65535)
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [39:0] dataOut,
  output logic        data_valid,
  output logic        timeout,
  output logic        checksum_error,
  output logic [2:0]  byte_count
);

  // The idle counter counts edges with no byte while a word is open.
  // When it already holds TIMEOUT_CYCLES-1 and yet another empty edge arrives, the word is dropped.
  // As a result, a byte that lands exactly on that edge still wins.
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

`ifdef DATA_RECEIVER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;
`endif

  state_t      state;
  logic [39:0] word;       // byte store for the word in progress
  logic [15:0] idle_cnt;
  logic        idle_expired;

  assign idle_expired = (idle_cnt == IDLE_LIMIT);

`ifdef DATA_RECEIVER_CHECKSUM_EN
  logic [7:0] csum;        // running XOR of the bytes stored so far
  logic       csum_err;
  assign checksum_error = csum_err;
`else
  assign checksum_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word       <= '0;
      idle_cnt   <= '0;
      byte_count <= '0;
      dataOut    <= '0;
      data_valid <= 1'b0;
      timeout    <= 1'b0;
`ifdef DATA_RECEIVER_CHECKSUM_EN
      csum       <= '0;
      csum_err   <= 1'b0;
`endif
    end else begin
      // Status flags are pulses and default low every cycle.
      data_valid <= 1'b0;
      timeout    <= 1'b0;
`ifdef DATA_RECEIVER_CHECKSUM_EN
      csum_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (byte_valid) begin
            word[7:0]  <= byte_in;
            byte_count <= 3'd1;
            state      <= COLLECT;
`ifdef DATA_RECEIVER_CHECKSUM_EN
            csum       <= byte_in;
`endif
          end
        end

        COLLECT: begin
          if (byte_valid) begin
            idle_cnt <= '0;
            case (byte_count)
              3'd1:    word[15:8]  <= byte_in;
              3'd2:    word[23:16] <= byte_in;
              3'd3:    word[31:24] <= byte_in;
              default: word[39:32] <= byte_in;
            endcase
`ifdef DATA_RECEIVER_CHECKSUM_EN
            csum <= csum ^ byte_in;
            if (byte_count == 3'd4) begin
              // All five data bytes are held. Wait for the checksum byte before publishing.
              byte_count <= 3'd5;
              state      <= CHECK;
            end else begin
              byte_count <= byte_count + 3'd1;
            end
`else
            if (byte_count == 3'd4) begin
              // The fifth byte goes straight into the output, because the store has no copy of it yet.
              dataOut    <= {byte_in, word[31:0]};
              data_valid <= 1'b1;
              byte_count <= 3'd0;
              state      <= IDLE;
            end else begin
              byte_count <= byte_count + 3'd1;
            end
`endif
          end else if (idle_expired) begin
            timeout    <= 1'b1;
            byte_count <= 3'd0;
            idle_cnt   <= '0;
            state      <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

`ifdef DATA_RECEIVER_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) begin
            idle_cnt   <= '0;
            byte_count <= 3'd0;
            state      <= IDLE;
            if (byte_in == csum) begin
              dataOut    <= word;
              data_valid <= 1'b1;
            end else begin
              csum_err <= 1'b1;
            end
          end else if (idle_expired) begin
            timeout    <= 1'b1;
            byte_count <= 3'd0;
            idle_cnt   <= '0;
            state      <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
`endif

        default: begin
          idle_cnt   <= '0;
          byte_count <= 3'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_receiver.sv
// Testbench for data_receiver: directed cases followed by a randomized byte stream.
// The stimulus side predicts outputs with a byte-queue model and queues those expectations.
// A monitor on the falling edge pops the expectations and compares them with the DUT outputs.
module tb_data_receiver;

  localparam int T = 16;
`ifdef DATA_RECEIVER_CHECKSUM_EN
  localparam int WORD_BYTES = 6;
`else
  localparam int WORD_BYTES = 5;
`endif

  localparam logic [2:0] F_DATA = 3'b100;
  localparam logic [2:0] F_TMO  = 3'b010;
  localparam logic [2:0] F_ERR  = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic [39:0] dataOut;
  logic        data_valid;
  logic        timeout;
  logic        checksum_error;
  logic [2:0]  byte_count;

  data_receiver #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .dataOut        (dataOut),
    .data_valid     (data_valid),
    .timeout        (timeout),
    .checksum_error (checksum_error),
    .byte_count     (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         idx;
    logic [2:0] bc;
  } cyc_t;

  typedef struct packed {
    int          idx;
    logic [2:0]  flags;
    logic [39:0] data;
  } ev_t;

  int          checks = 0;
  int          failures = 0;
  cyc_t        bc_q[$];
  ev_t         ev_q[$];
  logic [7:0]  held[$];
  int          idle = 0;
  int          scyc = 0;
  logic [39:0] exp_dout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one input cycle and predicts its result.
  // The task is entered just after a rising edge and returns just after the edge that samples the inputs.
  task automatic cycle(input bit v, input logic [7:0] b);
    ev_t         e;
    cyc_t        c;
    bit          have;
    logic [39:0] w;
    logic [7:0]  x;
    e = '0;
    have = 1'b0;
    byte_valid = v;
    byte_in = b;
    if (v) begin
      held.push_back(b);
      idle = 0;
      if (held.size() == WORD_BYTES) begin
        w = '0;
        x = '0;
        for (int i = 0; i < 5; i++) begin
          w[8*i +: 8] = held[i];
          x = x ^ held[i];
        end
        e.data = w;
        e.flags = F_DATA;
`ifdef DATA_RECEIVER_CHECKSUM_EN
        if (held[5] != x) e.flags = F_ERR;
`endif
        have = 1'b1;
        held.delete();
      end
    end else if (held.size() > 0) begin
      idle++;
      if (idle == T) begin
        e.flags = F_TMO;
        have = 1'b1;
        held.delete();
        idle = 0;
      end
    end
    c.bc = 3'(held.size());
    @(posedge clk);
    #1;
    c.idx = scyc;
    e.idx = scyc;
    if (have) ev_q.push_back(e);
    bc_q.push_back(c);
    scyc++;
  endtask

  // Sends the five bytes of w LSB first, with gap idle cycles between bytes.
  // In checksum mode the correct sixth byte is appended.
  task automatic send_word(input logic [39:0] w, input int gap);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (gap) cycle(1'b0, 8'h00);
      cycle(1'b1, w[8*i +: 8]);
      x = x ^ w[8*i +: 8];
    end
`ifdef DATA_RECEIVER_CHECKSUM_EN
    repeat (gap) cycle(1'b0, 8'h00);
    cycle(1'b1, x);
`endif
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    byte_in = 8'h00;
    #1 rst = 1'b0;
    held.delete();
    idle = 0;
    #1;
    chk("rst_async_dout", 64'(dataOut), 64'd0);
    chk("rst_async_bc", 64'(byte_count), 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [39:0] d, input logic dv,
                            input logic to, input logic [2:0] bc);
    @(negedge clk);
    #1;
    chk({name, "_dout"}, 64'(dataOut), 64'(d));
    chk({name, "_dvalid"}, 64'(data_valid), 64'(dv));
    chk({name, "_timeout"}, 64'(timeout), 64'(to));
    chk({name, "_bcount"}, 64'(byte_count), 64'(bc));
  endtask

  // Monitor: compares each sampled cycle against the queued expectations.
  always @(negedge clk) begin
    cyc_t       cur;
    ev_t        e;
    logic [2:0] exp_flags;
    if (!rst) begin
      bc_q.delete();
      ev_q.delete();
      exp_dout = '0;
      chk("reset_dout", 64'(dataOut), 64'd0);
      chk("reset_flags", 64'({data_valid, timeout, checksum_error}), 64'd0);
      chk("reset_bcount", 64'(byte_count), 64'd0);
    end else if (bc_q.size() > 0) begin
      cur = bc_q.pop_front();
      exp_flags = 3'b000;
      if (ev_q.size() > 0 && ev_q[0].idx == cur.idx) begin
        e = ev_q.pop_front();
        exp_flags = e.flags;
        if (e.flags == F_DATA) exp_dout = e.data;
      end
      chk("byte_count", 64'(byte_count), 64'(cur.bc));
      chk("flags", 64'({data_valid, timeout, checksum_error}), 64'(exp_flags));
      chk("dout", 64'(dataOut), 64'(exp_dout));
    end else begin
      chk("quiet_flags", 64'({data_valid, timeout, checksum_error}), 64'd0);
      chk("quiet_dout", 64'(dataOut), 64'(exp_dout));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n;
    // Reset state, checked while reset is still asserted
    #12;
    chk("init_dout", 64'(dataOut), 64'd0);
    chk("init_flags", 64'({data_valid, timeout, checksum_error}), 64'd0);
    chk("init_bcount", 64'(byte_count), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Bytes 55..11 with one-cycle gaps
    send_word(40'h1122334455, 1);
    expect_out("gap_word", 40'h1122334455, 1'b1, 1'b0, 3'd0);

    // Back-to-back bytes
    send_word(40'h0504030201, 0);
    expect_out("b2b_word", 40'h0504030201, 1'b1, 1'b0, 3'd0);

    // Partial word, then a full timeout gap
    cycle(1'b1, 8'h9a);
    cycle(1'b1, 8'h78);
    cycle(1'b1, 8'h56);
    repeat (T) cycle(1'b0, 8'h00);
    expect_out("timeout", 40'h0504030201, 1'b0, 1'b1, 3'd0);
    send_word(40'h123456789a, 0);
    expect_out("after_tmo", 40'h123456789a, 1'b1, 1'b0, 3'd0);

    // A byte on the expiry cycle is accepted
    cycle(1'b1, 8'haa);
    cycle(1'b1, 8'hbb);
    repeat (T - 1) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hcc);
    expect_out("expiry_byte", 40'h123456789a, 1'b0, 1'b0, 3'd3);
    cycle(1'b1, 8'hdd);
    cycle(1'b1, 8'hee);
`ifdef DATA_RECEIVER_CHECKSUM_EN
    cycle(1'b1, 8'haa ^ 8'hbb ^ 8'hcc ^ 8'hdd ^ 8'hee);
`endif
    expect_out("expiry_word", 40'heeddccbbaa, 1'b1, 1'b0, 3'd0);

    // Reset mid-word: the next byte is byte 1, and no timeout follows
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'h44);
    do_reset();
    send_word(40'h123456789a, 0);
    expect_out("after_rst", 40'h123456789a, 1'b1, 1'b0, 3'd0);

`ifdef DATA_RECEIVER_CHECKSUM_EN
    send_word(40'h1122334455, 0);
    expect_out("csum_ok", 40'h1122334455, 1'b1, 1'b0, 3'd0);
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'h44);
    cycle(1'b1, 8'h33);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h00);
    @(negedge clk);
    #1;
    chk("csum_bad_err", 64'(checksum_error), 64'd1);
    chk("csum_bad_dout", 64'(dataOut), 64'h1122334455);
`endif

    // Randomized stream
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else if (r < 5) begin
        n = $urandom_range(T - 2, T + 1);
        repeat (n) cycle(1'b0, 8'h00);
      end else if (r < 10) begin
        send_word({$urandom, 8'($urandom)}, $urandom_range(0, 2));
      end else begin
        cycle($urandom_range(0, 99) < 65, 8'($urandom));
      end
    end

    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("events_drained", 64'(ev_q.size()), 64'd0);
    chk("cycles_drained", 64'(bc_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_receiver.md
DATA_RECEIVER -- requirements
Module: data_receiver

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum idle clock cycles allowed between bytes of one word (legal range 2..65535).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port byte_in  input  8  received byte from the UART receiver.
REQ-005 The block SHALL have port byte_valid  input  1  single-cycle strobe; byte_in is valid when high.
REQ-006 The block SHALL have port dataOut  output  40  last complete reassembled word, registered.
REQ-007 The block SHALL have port data_valid  output  1  single-cycle pulse when dataOut updates.
REQ-008 The block SHALL have port timeout  output  1  single-cycle pulse when a partial word is discarded.
REQ-009 The block SHALL have port checksum_error  output  1  single-cycle pulse on checksum mismatch; tied 0 when checksum is compiled out.
REQ-010 The block SHALL have port byte_count  output  3  number of bytes held for the word in progress (0..5).

Function
REQ-011 The block SHALL reassemble words LSB byte first: the 1st byte goes to bits [7:0], the 2nd to [15:8], up to the 5th to [39:32].
REQ-012 The block SHALL implement states IDLE (byte_count=0), COLLECT (1..4 bytes held) and CHECK (5 bytes held, checksum build only).
REQ-013 In IDLE, a byte_valid SHALL store the byte, set byte_count=1, and enter COLLECT.
REQ-014 In COLLECT, each byte_valid SHALL store the byte at slot byte_count and increment byte_count.
REQ-015 Without checksum, the edge sampling the 5th byte_valid SHALL load the full 40-bit word into dataOut, pulse data_valid high for exactly the next cycle, and return to IDLE with byte_count=0.
REQ-016 dataOut SHALL hold its value until the next successful word; partial words SHALL never be visible on dataOut.
REQ-017 The idle counter SHALL clear on every accepted byte, count in COLLECT/CHECK, and hold at 0 in IDLE.
REQ-018 If the idle counter reaches TIMEOUT_CYCLES-1 without byte_valid, the block SHALL discard the partial word, pulse timeout for one cycle, and go to IDLE with byte_count=0.
REQ-019 If byte_valid arrives in the same cycle as timeout expiry, the byte SHALL be accepted and no timeout SHALL occur.
REQ-020 byte_valid held high for N consecutive cycles SHALL be treated as N bytes.
REQ-021 data_valid, timeout and checksum_error SHALL be mutually exclusive in any cycle.

Reset
REQ-022 rst low SHALL immediately clear dataOut=0, data_valid=0, timeout=0, checksum_error=0, byte_count=0, the idle counter, and the byte store, and force state IDLE, regardless of clk.
REQ-023 Assertion of rst mid-word SHALL discard the partial word with no timeout pulse; the first byte_valid after deassertion SHALL be treated as byte 1.

Configuration
REQ-024 Macro DATA_RECEIVER_CHECKSUM_EN SHALL select checksum mode; when defined, after the 5th byte the block SHALL enter CHECK and wait for a 6th byte.
REQ-025 With DATA_RECEIVER_CHECKSUM_EN defined, a 6th byte equal to the XOR of bytes 1..5 SHALL update dataOut and pulse data_valid; a mismatch SHALL pulse checksum_error, leave dataOut unchanged, and return to IDLE.
REQ-026 With DATA_RECEIVER_CHECKSUM_EN defined, CHECK SHALL be subject to the REQ-018 timeout.
REQ-027 Without DATA_RECEIVER_CHECKSUM_EN, state CHECK SHALL not exist, words SHALL be 5 bytes, and checksum_error SHALL be constant 0.

Verification
REQ-028 Bytes 55,44,33,22,11 strobed with 1-cycle gaps -> dataOut=0x1122334455 with one data_valid pulse, byte_count returns to 0.
REQ-029 Bytes 9a,78,56 followed by a gap of TIMEOUT_CYCLES cycles -> timeout pulse, dataOut unchanged; then 9a,78,56,34,12 -> dataOut=0x123456789a.
REQ-030 Bytes 55,44 then rst low for 1 cycle, then 9a,78,56,34,12 -> dataOut=0 during reset, then 0x123456789a with no timeout pulse.
REQ-031 Five back-to-back byte_valid cycles carrying 01..05 -> dataOut=0x0504030201 one cycle after the 5th byte is sampled.
REQ-032 With DATA_RECEIVER_CHECKSUM_EN: bytes 55,44,33,22,11,11 -> dataOut=0x1122334455 with data_valid; bytes 55,44,33,22,11,00 -> checksum_error pulse, dataOut unchanged.
REQ-033 A byte arriving exactly at the timeout expiry cycle -> byte accepted, byte_count increments, no timeout pulse.
